// File: rtl/fixed_alu_scheduler_pkg.sv
// Shared definitions for the fixed-point ALU scheduler.
//   - scheduler state encoding (SCH_*)
//   - response flag bit positions (FLG_*)
//   - ALU opcode values (OP_*), passed through to the ALU unchanged
//   - make_flags(): packs the four status bits into a rsp_flags word
package fixed_alu_scheduler_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_ISSUE = 2'd1,
    SCH_WAIT  = 2'd2,
    SCH_RESP  = 2'd3
  } sch_state_e;

  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_DBZ = 2;
  localparam int FLG_TMO = 3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;

  // Build a flag word with each status bit at its named position.
  function automatic logic [3:0] make_flags(input logic tmo, input logic dbz,
                                            input logic unf, input logic ovf);
    logic [3:0] f;
    f          = 4'b0000;
    f[FLG_TMO] = tmo;
    f[FLG_DBZ] = dbz;
    f[FLG_UNF] = unf;
    f[FLG_OVF] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/fixed_alu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req upward starting at last+1 (wrapping modulo N) and grants the
// first set bit.
//   req    [N-1:0]  : pending requests
//   last   [IW-1:0] : index of the most recently accepted requester
//   grant  [N-1:0]  : one-hot grant (all zero when req is zero)
//   gnt_id [IW-1:0] : index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // Rotating priority search; the first hit after 'last' wins.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx_s        = IW'((int'(last) + k) % N);
      hit_s        = !found_s && req[idx_s];
      grant[idx_s] = hit_s;
      gnt_id       = hit_s ? idx_s : gnt_id;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/fixed_alu_scheduler.sv
// Shares one Q16.16 fixed-point ALU between NUM_REQ requesters.
// One operation is in flight at a time: IDLE arbitrates and accepts, ISSUE
// pulses alu_start, WAIT waits for alu_done (guarded by a watchdog), RESP
// holds the tagged response until the consumer takes it.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready [NUM_REQ]   : per-requester handshake (ready one-hot)
//   req_a, req_b [32*NUM_REQ]       : Q16.16 operands, requester i at [32i+:32]
//   req_op [4*NUM_REQ]              : opcode per requester
//   rsp_valid/rsp_ready             : response handshake
//   rsp_id, rsp_result, rsp_flags   : response payload {tmo, dbz, unf, ovf}
//   alu_operand_a/b, alu_operation  : operands/opcode driven to the ALU
//   alu_start                       : one-cycle start pulse
//   alu_result, alu_done, alu_*     : ALU result and status
module fixed_alu_scheduler
  import fixed_alu_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [4*NUM_REQ-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [31:0]            rsp_result,
  output logic [3:0]             rsp_flags,
  output logic [31:0]            alu_operand_a,
  output logic [31:0]            alu_operand_b,
  output logic [3:0]             alu_operation,
  output logic                   alu_start,
  input  logic [31:0]            alu_result,
  input  logic                   alu_done,
  input  logic                   alu_overflow,
  input  logic                   alu_underflow,
  input  logic                   alu_div_by_zero
);

  // Watchdog count at which a WAIT cycle without done gives up.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  sch_state_e        state_r;
  sch_state_e        next_state_s;
  logic [IDW-1:0]    last_r;
  logic [IDW-1:0]    id_r;
  logic [31:0]       a_r;
  logic [31:0]       b_r;
  logic [3:0]        op_r;
  logic [7:0]        cnt_r;
  logic [IDW-1:0]    rsp_id_r;
  logic [31:0]       rsp_result_r;
  logic [3:0]        rsp_flags_r;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     gnt_id_s;
  logic               accept_s;
  logic               wait_done_s;
  logic               wait_tmo_s;
  logic [31:0]        a_arr_s  [NUM_REQ];
  logic [31:0]        b_arr_s  [NUM_REQ];
  logic [3:0]         op_arr_s [NUM_REQ];

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req    (req_valid),
    .last   (last_r),
    .grant  (grant_s),
    .gnt_id (gnt_id_s)
  );

  // Unpack the flat operand buses into per-requester arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr_s[i]  = req_a[32*i +: 32];
      b_arr_s[i]  = req_b[32*i +: 32];
      op_arr_s[i] = req_op[4*i +: 4];
    end
  end

  // Event decode; done takes priority over the watchdog in the same cycle.
  always_comb begin
    accept_s    = (state_r == SCH_IDLE) && (|grant_s);
    wait_done_s = (state_r == SCH_WAIT) && alu_done;
    wait_tmo_s  = (state_r == SCH_WAIT) && !alu_done && (cnt_r == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SCH_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SCH_IDLE: begin
        if (accept_s) begin
          next_state_s = SCH_ISSUE;
        end else begin
          next_state_s = SCH_IDLE;
        end
      end
      SCH_ISSUE: next_state_s = SCH_WAIT;
      SCH_WAIT: begin
        if (wait_done_s || wait_tmo_s) begin
          next_state_s = SCH_RESP;
        end else begin
          next_state_s = SCH_WAIT;
        end
      end
      SCH_RESP: begin
        if (rsp_ready) begin
          next_state_s = SCH_IDLE;
        end else begin
          next_state_s = SCH_RESP;
        end
      end
      default: next_state_s = SCH_IDLE;
    endcase
  end

  // State-decoded outputs; req_ready is the live grant so the handshake
  // completes in the arbitration cycle itself.
  always_comb begin
    req_ready = '0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_r)
      SCH_IDLE:  req_ready = grant_s;
      SCH_ISSUE: alu_start = 1'b1;
      SCH_WAIT:  alu_start = 1'b0;
      SCH_RESP:  rsp_valid = 1'b1;
      default:   req_ready = '0;
    endcase
  end

  // Operation latch, round-robin pointer, watchdog and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r       <= IDW'(NUM_REQ - 1);
      id_r         <= '0;
      a_r          <= 32'h0000_0000;
      b_r          <= 32'h0000_0000;
      op_r         <= 4'h0;
      cnt_r        <= 8'd0;
      rsp_id_r     <= '0;
      rsp_result_r <= 32'h0000_0000;
      rsp_flags_r  <= 4'b0000;
    end else begin
      case (state_r)
        SCH_IDLE: begin
          if (accept_s) begin
            a_r    <= a_arr_s[gnt_id_s];
            b_r    <= b_arr_s[gnt_id_s];
            op_r   <= op_arr_s[gnt_id_s];
            id_r   <= gnt_id_s;
            last_r <= gnt_id_s;
          end
        end
        SCH_ISSUE: cnt_r <= 8'd0;
        SCH_WAIT: begin
          cnt_r <= cnt_r + 8'd1;
          if (wait_done_s) begin
            rsp_id_r     <= id_r;
            rsp_result_r <= alu_result;
            rsp_flags_r  <= make_flags(1'b0, alu_div_by_zero, alu_underflow, alu_overflow);
          end else if (wait_tmo_s) begin
            rsp_id_r     <= id_r;
            rsp_result_r <= 32'h0000_0000;
            rsp_flags_r  <= make_flags(1'b1, 1'b0, 1'b0, 1'b0);
          end
        end
        SCH_RESP: cnt_r <= cnt_r;
        default:  cnt_r <= 8'd0;
      endcase
    end
  end

  assign alu_operand_a = a_r;
  assign alu_operand_b = b_r;
  assign alu_operation = op_r;
  assign rsp_id        = rsp_id_r;
  assign rsp_result    = rsp_result_r;
  assign rsp_flags     = rsp_flags_r;

endmodule

// File: doc/fixed_alu_scheduler.md
# fixed_alu_scheduler

Round-robin scheduler that shares one Q16.16 fixed-point ALU between `NUM_REQ` requesters. It accepts one operation at a time over per-requester valid/ready handshakes and drives the ALU's start/done protocol. It returns the result and status flags on a single tagged response channel. A watchdog returns an error response if the ALU never completes. It sits between the calculator front-end clients and the shared fixed-point ALU instance.

## Interface
- `NUM_REQ`, 4: number of requesters; 2–8.
- `TIMEOUT`, 15: cycles from start-issue before an operation is abandoned; 4–255.
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `req_a`, `req_b`  in  32*NUM_REQ  Q16.16 operands; requester i occupies bits [32i+31:32i].
- `req_op`  in  4*NUM_REQ  opcode per requester (ALU opcode set).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  $clog2(NUM_REQ)  requester index of the response.
- `rsp_result`  out  32  Q16.16 result.
- `rsp_flags`  out  4  {timeout, div_by_zero, underflow, overflow}.
- `alu_operand_a`, `alu_operand_b`  out  32  ALU operands.
- `alu_operation`  out  4  ALU opcode.
- `alu_start`  out  1  one-cycle start pulse.
- `alu_result`  in  32  ALU result.
- `alu_done`, `alu_overflow`, `alu_underflow`, `alu_div_by_zero`  in  1  ALU status.

## Operation
- FSM states:
  - IDLE: arbitrate; on accept → ISSUE.
  - ISSUE: `alu_start`=1 for this cycle only; → WAIT.
  - WAIT: count cycles; on `alu_done` capture → RESP; on count reaching TIMEOUT → RESP with timeout.
  - RESP: `rsp_valid`=1 until `rsp_ready`; then → IDLE.
- Arbitration, IDLE only:
  - Winner is the first set `req_valid` bit searching upward from `last+1`, modulo NUM_REQ.
  - `req_ready[winner]`=1 combinationally in the same cycle; the handshake completes in that cycle.
  - On accept, latch a, b, op and id, and set `last`=winner.
  - `last` advances only on accept.
- `req_ready` is all-zero in ISSUE, WAIT and RESP.
- `alu_operand_a`, `alu_operand_b` and `alu_operation` are driven from the latched registers and held stable from ISSUE through the capture cycle. The ALU's divide-by-zero output is combinational, so it is sampled together with `alu_done`.
- Capture on `alu_done` in WAIT:
  - `rsp_result`=`alu_result`.
  - `rsp_flags`={0, `alu_div_by_zero`, `alu_underflow`, `alu_overflow`}.
- Timeout: `rsp_result`=0 and `rsp_flags`=4'b1000.
- `alu_done` is ignored outside WAIT.
- Opcodes are passed through unchecked; an undefined opcode returns whatever the ALU produces.
- A stalled `rsp_ready` holds RESP and blocks all new grants. `rsp_*` stay stable while `rsp_valid`=1.

## Timing
- Reset, effective at the next clk edge from any state:
  - State=IDLE, `last`=NUM_REQ-1, so requester 0 has first priority.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0.
  - `alu_start`=0, ALU operand/op outputs=0, watchdog counter=0.
- Reset mid-WAIT abandons the operation silently, with no response. The ALU shares `reset`.
- Cycle sequence:
  - Accept in cycle A; ISSUE in A+1.
  - With the nominal ALU, `alu_done`=1 in A+4.
  - `rsp_valid`=1 from A+5.
- Minimum spacing between accepts is 6 cycles when `rsp_ready` is tied high.
- Watchdog counter clears in ISSUE and increments each WAIT cycle. Timeout fires in the WAIT cycle where the count equals TIMEOUT-1 and `alu_done`=0.
- If done and timeout occur in the same cycle, done wins.
- `rsp_ready` sampled in RESP completes the transfer in that cycle. The next accept is possible at the earliest one cycle later, in IDLE.

## Structure
- Add to `alu_defines.v`:
  - scheduler state encodings (SCH_IDLE, SCH_ISSUE, SCH_WAIT, SCH_RESP);
  - flag bit indices (FLG_OVF=0, FLG_UNF=1, FLG_DBZ=2, FLG_TMO=3).
- The existing opcode defines (`OP_*`) are reused unchanged.
- One sub-module: `rr_arbiter` (parameter N; inputs `req` and `last`; outputs one-hot `grant` and index `gnt_id`), combinational.
- Bench instantiates the real `fixed_alu` plus a stub ALU that never asserts done.

## Test plan
- **Single add:** requester 1 sends OP_ADD with a=0x00018000, b=0x00024000 → `rsp_valid` 5 cycles after accept with `rsp_id`=1, `rsp_result`=0x0003C000, `rsp_flags`=0.
- **Round-robin:** all four `req_valid` held high from reset → grants in order 0,1,2,3,0; no requester is granted twice before the others.
- **Divide by zero:** requester 2 sends OP_DIV with a=0x00010000, b=0 → `rsp_flags`=4'b0100 and `rsp_id`=2.
- **Backpressure:** `rsp_ready`=0 for 10 cycles with requesters 0 and 3 pending → `rsp_*` stable, `req_ready`=0 throughout; the next grant comes one cycle after `rsp_ready` rises.
- **Timeout:** stub ALU, TIMEOUT=15 → `rsp_valid` with `rsp_flags`=4'b1000 and `rsp_result`=0 exactly 15 WAIT cycles after ISSUE; a late `alu_done` in IDLE is ignored.
- **Reset mid-WAIT:** reset asserted in WAIT → next cycle all outputs at reset values, no response; requester 0 is granted first afterwards.
